config_mux: RTL and testbench
=============================

CONFIG_MUX -- requirements
Module: config_mux

Interface
REQ-001 Parameter N_INPUTS, default 26: number of selectable data inputs, legal range 2..256.
REQ-002 Parameter SEL_WIDTH, default 5: selector width; SHALL be at least ceil(log2(N_INPUTS)), else elaboration error.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port nreset, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port data_in, input, N_INPUTS: candidate data bits.
REQ-006 Port data_out, output, 1: registered selected bit.
REQ-007 Port config_enable, input, 1: shift the configuration chain by one bit this cycle.
REQ-008 Port config_in, input, 1: serial configuration bit, LSB of selector first.
REQ-009 Port config_out, output, 1: chain output, equals shadow[0], for daisy-chaining.
REQ-010 Port config_latch, input, 1: transfer shadow selector into active selector.
REQ-011 Port config_ready, output, 1: high when SEL_WIDTH bits have been shifted since the last accepted latch or reset.
REQ-012 Port config_error, output, 1: sticky flag, latch request rejected.

Function
REQ-013 Shadow register SHALL be SEL_WIDTH bits; on config_enable: shadow <= {config_in, shadow[SEL_WIDTH-1:1]}.
REQ-014 Shift counter SHALL increment per shift, saturating at SEL_WIDTH; config_ready = (count == SEL_WIDTH).
REQ-015 config_latch with config_ready=1: active_sel <= shadow (pre-shift value), active_valid <= 1, count <= 0 (or 1 if config_enable is high in the same cycle).
REQ-016 config_latch with config_ready=0: active_sel and active_valid unchanged, config_error <= 1.
REQ-017 Shift and accepted latch in the same cycle SHALL both take effect: latch uses the shadow value before the shift.
REQ-018 Selection SHALL be a binary tree: stage k chooses halves by active_sel bit k, from MSB to LSB, with inputs zero-padded to 2^SEL_WIDTH.
REQ-019 active_sel >= N_INPUTS SHALL select constant 0.
REQ-020 active_valid=0 SHALL force data_out to 0.
REQ-021 Latency without the macro SHALL be 1 cycle: data_out(t+1) = data_in[active_sel](t).
REQ-022 A new active_sel SHALL affect data_out starting the cycle after the latch edge plus pipeline latency; no glitch to a third input.
REQ-023 config_error SHALL clear only on reset.

Reset
REQ-024 While nreset=0: shadow, active_sel, count, active_valid, config_error and all pipeline registers are 0.
REQ-025 Outputs during reset: data_out=0, config_out=0, config_ready=0, config_error=0.
REQ-026 Reset mid-shift SHALL discard partial configuration; the first post-reset edge is treated as a fresh shift.
REQ-027 Deassertion SHALL take effect on the first clock edge after nreset rises; no operation is lost beyond that edge.

Configuration
REQ-028 Macro CONFIG_MUX_PIPELINE_EN, when defined: insert a register after tree stage floor(SEL_WIDTH/2) carrying the partial result plus the remaining selector bits; latency becomes 2 cycles.
REQ-029 Without CONFIG_MUX_PIPELINE_EN: purely combinational tree followed by the output register; latency 1.
REQ-030 The configuration chain behaviour (REQ-013..017) SHALL be identical in both builds.

Verification
REQ-031 Reset, then shift 5 bits 1,1,0,0,0 (sel=3), latch, drive data_in=26'h0000008 -> config_ready=1 before latch; data_out=1 one cycle (two with macro) after latch edge; config_out sequence matches shifted-out bits.
REQ-032 Latch after only 3 shifts -> config_error=1, active_valid stays 0, data_out stays 0.
REQ-033 Shift sel=27 (out of range), latch, data_in all ones -> data_out=0.
REQ-034 Active sel=3; shift sel=25 while toggling data_in[3]; latch and shift in the same cycle -> data_out tracks bit 3 until latch, bit 25 after; count=1 after that edge.
REQ-035 Assert nreset after 4 shifts and again with a valid config active -> all outputs 0 asynchronously; after release, 5 fresh shifts are needed for config_ready.
REQ-036 Parameter sweep N_INPUTS=2,26,256 with random sel and data -> data_out matches the model at the configured latency.

Source files
------------

// File: rtl/config_mux_if.sv
// ---------------------------------------------------------------------------
// config_mux_if
//
// Bundle of the data path and serial configuration chain signals of
// config_mux. Clock and reset are kept outside the interface.
//
// Parameter:
//   N_INPUTS      width of the candidate data vector
//
// Signals:
//   data_in       [N_INPUTS-1:0] candidate data bits          (master -> slave)
//   data_out      registered selected bit                     (slave -> master)
//   config_enable shift the configuration chain this cycle    (master -> slave)
//   config_in     serial configuration bit, selector LSB first (master -> slave)
//   config_out    chain output (shadow bit 0) for daisy-chain  (slave -> master)
//   config_latch  request transfer of shadow into active sel   (master -> slave)
//   config_ready  a full selector has been shifted in          (slave -> master)
//   config_error  sticky: a latch request was rejected         (slave -> master)
//
// Modports:
//   master  the side that drives data and configuration (bench / upstream)
//   slave   the multiplexer itself
// ---------------------------------------------------------------------------
interface config_mux_if #(
    parameter int N_INPUTS = 26
) ();

    logic [N_INPUTS-1:0] data_in;
    logic                data_out;
    logic                config_enable;
    logic                config_in;
    logic                config_out;
    logic                config_latch;
    logic                config_ready;
    logic                config_error;

    modport master (
        output data_in,
        output config_enable,
        output config_in,
        output config_latch,
        input  data_out,
        input  config_out,
        input  config_ready,
        input  config_error
    );

    modport slave (
        input  data_in,
        input  config_enable,
        input  config_in,
        input  config_latch,
        output data_out,
        output config_out,
        output config_ready,
        output config_error
    );

endinterface

// File: rtl/config_mux.sv
// ---------------------------------------------------------------------------
// config_mux
//
// Serially configured N_INPUTS:1 bit multiplexer. A selector is shifted in
// LSB first through a SEL_WIDTH-bit shadow register, then transferred to the
// active selector by a latch request once a full selector has been shifted.
// The selected bit is picked by a binary tree over the zero-padded input
// vector and registered on data_out.
//
// Parameters:
//   N_INPUTS   number of selectable inputs (2..256)
//   SEL_WIDTH  selector width, at least ceil(log2(N_INPUTS))
//
// Ports:
//   clock      single clock, rising edge
//   nreset     asynchronous active-low reset
//   bus        config_mux_if.slave: data_in, data_out, config_enable,
//              config_in, config_out, config_latch, config_ready,
//              config_error
//
// Build option:
//   CONFIG_MUX_PIPELINE_EN  when defined, a register is inserted after tree
//              stage SEL_WIDTH/2 (partial result plus remaining selector
//              bits), so data_out lags data_in by 2 cycles instead of 1.
//              The configuration chain behaves identically in both builds.
// ---------------------------------------------------------------------------
module config_mux #(
    parameter int N_INPUTS  = 26,
    parameter int SEL_WIDTH = 5
) (
    input  logic        clock,
    input  logic        nreset,
    config_mux_if.slave bus
);

    localparam int TREE_W = 2 ** SEL_WIDTH;
    localparam int CNT_W  = $clog2(SEL_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_WIDTH);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (N_INPUTS < 2 || N_INPUTS > 256) begin : g_bad_inputs
        $error("config_mux: N_INPUTS=%0d outside legal range 2..256", N_INPUTS);
    end
    if (SEL_WIDTH < $clog2(N_INPUTS)) begin : g_bad_sel_width
        $error("config_mux: SEL_WIDTH=%0d too small for N_INPUTS=%0d", SEL_WIDTH, N_INPUTS);
    end

    // -----------------------------------------------------------------------
    // Configuration chain
    // -----------------------------------------------------------------------
    logic [SEL_WIDTH-1:0] shadow_d, shadow_q;
    logic [CNT_W-1:0]     count_d, count_q;
    logic [SEL_WIDTH-1:0] active_sel_d, active_sel_q;
    logic                 active_valid_d, active_valid_q;
    logic                 config_error_d, config_error_q;

    logic [SEL_WIDTH:0]   shift_w;
    logic                 ready_w;
    logic                 latch_ok_w;
    logic [CNT_W-1:0]     count_base_w;

    always_comb begin
        shadow_d       = shadow_q;
        count_d        = count_q;
        active_sel_d   = active_sel_q;
        active_valid_d = active_valid_q;
        config_error_d = config_error_q;

        // Concatenate-then-slice keeps the shift legal even for SEL_WIDTH=1.
        shift_w      = {bus.config_in, shadow_q};
        ready_w      = (count_q == CNT_FULL);
        latch_ok_w   = bus.config_latch && ready_w;
        // An accepted latch restarts the count; a shift in the same cycle
        // then counts as the first bit of the next selector.
        count_base_w = latch_ok_w ? '0 : count_q;

        // The latch always sees the shadow value from before this edge's shift.
        if (latch_ok_w) begin
            active_sel_d   = shadow_q;
            active_valid_d = 1'b1;
        end else if (bus.config_latch) begin
            config_error_d = 1'b1;
        end

        if (bus.config_enable) begin
            shadow_d = shift_w[SEL_WIDTH:1];
            if (count_base_w != CNT_FULL) begin
                count_d = count_base_w + CNT_W'(1);
            end else begin
                count_d = count_base_w;
            end
        end else begin
            count_d = count_base_w;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            shadow_q       <= '0;
            count_q        <= '0;
            active_sel_q   <= '0;
            active_valid_q <= 1'b0;
            config_error_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            count_q        <= count_d;
            active_sel_q   <= active_sel_d;
            active_valid_q <= active_valid_d;
            config_error_q <= config_error_d;
        end
    end

    // -----------------------------------------------------------------------
    // Selection tree
    // -----------------------------------------------------------------------
    // Zero padding up to a power of two makes any selector >= N_INPUTS land
    // on a constant 0 without a separate range compare.
    logic [TREE_W-1:0] padded_w;

    if (TREE_W > N_INPUTS) begin : g_pad
        assign padded_w = {{(TREE_W - N_INPUTS){1'b0}}, bus.data_in};
    end else begin : g_no_pad
        assign padded_w = bus.data_in[TREE_W-1:0];
    end

`ifdef CONFIG_MUX_PIPELINE_EN
    localparam int PIPE_LVL = SEL_WIDTH / 2;
    localparam int PART_W   = 2 ** (SEL_WIDTH - PIPE_LVL);
    localparam int REM_W    = SEL_WIDTH - PIPE_LVL;

    logic [PART_W-1:0] part_d, part_q;
    logic [REM_W-1:0]  sel_rem_d, sel_rem_q;
    logic              valid_pipe_d, valid_pipe_q;
`endif

    // Stage gi halves its source using selector bit SEL_WIDTH-1-gi, so the
    // MSB decides first and the LSB picks the final bit.
    genvar gi;
    for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_stage
        localparam int OUT_W = 2 ** (SEL_WIDTH - gi - 1);

        logic [2*OUT_W-1:0] src_w;
        logic               sel_bit_w;
        logic [OUT_W-1:0]   out_w;

        if (gi == 0) begin : g_src_first
`ifdef CONFIG_MUX_PIPELINE_EN
            if (PIPE_LVL == 0) begin : g_from_pipe
                assign src_w = part_q;
            end else begin : g_from_input
                assign src_w = padded_w;
            end
`else
            assign src_w = padded_w;
`endif
        end else begin : g_src_next
`ifdef CONFIG_MUX_PIPELINE_EN
            if (gi == PIPE_LVL) begin : g_from_pipe
                assign src_w = part_q;
            end else begin : g_from_prev
                assign src_w = g_stage[gi-1].out_w;
            end
`else
            assign src_w = g_stage[gi-1].out_w;
`endif
        end

`ifdef CONFIG_MUX_PIPELINE_EN
        // Stages behind the pipeline register must use the selector bits
        // that travelled with the partial result, never the live selector,
        // so a selector change cannot mix halves of two different choices.
        if (gi < PIPE_LVL) begin : g_sel_live
            assign sel_bit_w = active_sel_q[SEL_WIDTH-1-gi];
        end else begin : g_sel_piped
            assign sel_bit_w = sel_rem_q[SEL_WIDTH-1-gi];
        end
`else
        assign sel_bit_w = active_sel_q[SEL_WIDTH-1-gi];
`endif

        assign out_w = sel_bit_w ? src_w[2*OUT_W-1:OUT_W] : src_w[OUT_W-1:0];
    end

    logic tree_bit_w;
    assign tree_bit_w = g_stage[SEL_WIDTH-1].out_w[0];

    // -----------------------------------------------------------------------
    // Output register (and optional mid-tree register)
    // -----------------------------------------------------------------------
    logic data_out_d, data_out_q;

`ifdef CONFIG_MUX_PIPELINE_EN
    if (PIPE_LVL == 0) begin : g_tap_input
        always_comb part_d = padded_w;
    end else begin : g_tap_stage
        always_comb part_d = g_stage[PIPE_LVL-1].out_w;
    end

    always_comb begin
        sel_rem_d    = active_sel_q[REM_W-1:0];
        valid_pipe_d = active_valid_q;
        data_out_d   = valid_pipe_q & tree_bit_w;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            part_q       <= '0;
            sel_rem_q    <= '0;
            valid_pipe_q <= 1'b0;
        end else begin
            part_q       <= part_d;
            sel_rem_q    <= sel_rem_d;
            valid_pipe_q <= valid_pipe_d;
        end
    end
`else
    always_comb begin
        data_out_d = active_valid_q & tree_bit_w;
    end
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            data_out_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.config_out   = shadow_q[0];
    assign bus.config_ready = ready_w;
    assign bus.config_error = config_error_q;

endmodule

// File: tb/tb_config_mux.sv
// ---------------------------------------------------------------------------
// tb_config_mux
//
// Directed bench for config_mux. Three instances (N_INPUTS = 2, 26, 256)
// share clock and reset; the 26-input instance carries the directed
// scenarios, all three take part in the random selector/data sweep.
// Inputs change just after the falling edge, outputs are sampled on the
// following falling edge, i.e. after exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_config_mux;

`ifdef CONFIG_MUX_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock;
    logic nreset;
    int   checks = 0;
    int   errors = 0;

    config_mux_if #(.N_INPUTS(2))   bus2   ();
    config_mux_if #(.N_INPUTS(26))  bus26  ();
    config_mux_if #(.N_INPUTS(256)) bus256 ();

    config_mux #(.N_INPUTS(2),   .SEL_WIDTH(1)) dut2   (.clock(clock), .nreset(nreset), .bus(bus2));
    config_mux #(.N_INPUTS(26),  .SEL_WIDTH(5)) dut26  (.clock(clock), .nreset(nreset), .bus(bus26));
    config_mux #(.N_INPUTS(256), .SEL_WIDTH(8)) dut256 (.clock(clock), .nreset(nreset), .bus(bus256));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_all();
        bus2.config_enable   = 1'b0; bus2.config_in   = 1'b0; bus2.config_latch   = 1'b0;
        bus26.config_enable  = 1'b0; bus26.config_in  = 1'b0; bus26.config_latch  = 1'b0;
        bus256.config_enable = 1'b0; bus256.config_in = 1'b0; bus256.config_latch = 1'b0;
    endtask

    // Pulse reset between two falling edges, released 2 time units after one.
    task automatic pulse_reset();
        #1 nreset = 1'b0;
        tick();
        #2 nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle_all();
        bus2.data_in = '0; bus26.data_in = '0; bus256.data_in = '0;
        tick(); tick();
        checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out: got %b expected 0", bus26.data_out); end
        checks++; if (bus26.config_out !== 1'b0) begin errors++; $display("FAIL reset_config_out: got %b expected 0", bus26.config_out); end
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL reset_config_ready: got %b expected 0", bus26.config_ready); end
        checks++; if (bus26.config_error !== 1'b0) begin errors++; $display("FAIL reset_config_error: got %b expected 0", bus26.config_error); end
        #2 nreset = 1'b1;
        $display("reset released");
    endtask

    // Shift sel=3 (1,1,0,0,0), watch the chain output, latch, see data_in[3].
    task automatic test_basic_select();
        logic [4:0] bits;
        logic [4:0] co_exp;
        bits   = 5'b00011;
        co_exp = 5'b10000;
        for (int k = 0; k < 5; k++) begin
            bus26.config_enable = 1'b1;
            bus26.config_in     = bits[k];
            tick();
            checks++; if (bus26.config_out !== co_exp[k]) begin errors++; $display("FAIL basic_config_out[%0d]: got %b expected %b", k, bus26.config_out, co_exp[k]); end
            checks++; if (bus26.config_ready !== (k == 4)) begin errors++; $display("FAIL basic_ready[%0d]: got %b expected %b", k, bus26.config_ready, (k == 4)); end
        end
        bus26.config_enable = 1'b0;
        bus26.data_in       = 26'h0000008;
        bus26.config_latch  = 1'b1;
        tick();
        bus26.config_latch  = 1'b0;
        $display("latch sel=3 data_in=%h", bus26.data_in);
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_latch: got %b expected 0", bus26.config_ready); end
        checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL basic_out_at_latch: got %b expected 0", bus26.data_out); end
        for (int k = 1; k <= LAT; k++) begin
            tick();
            checks++; if (bus26.data_out !== (k == LAT)) begin errors++; $display("FAIL basic_out_lat%0d: got %b expected %b", k, bus26.data_out, (k == LAT)); end
        end
    endtask

    // Latch after 3 shifts is refused: error set, output stays 0.
    task automatic test_early_latch();
        logic [2:0] bits;
        bits = 3'b011;
        pulse_reset();
        bus26.data_in = '1;
        for (int k = 0; k < 3; k++) begin
            bus26.config_enable = 1'b1;
            bus26.config_in     = bits[k];
            tick();
        end
        bus26.config_enable = 1'b0;
        bus26.config_latch  = 1'b1;
        tick();
        bus26.config_latch  = 1'b0;
        $display("early latch after 3 shifts");
        checks++; if (bus26.config_error !== 1'b1) begin errors++; $display("FAIL early_error: got %b expected 1", bus26.config_error); end
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL early_ready: got %b expected 0", bus26.config_ready); end
        for (int k = 0; k <= LAT; k++) begin
            tick();
            checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL early_data_out[%0d]: got %b expected 0", k, bus26.data_out); end
        end
    endtask

    // sel=27 is out of range: all-ones data still gives 0.
    task automatic test_out_of_range();
        logic [4:0] bits;
        bits = 5'd27;
        for (int k = 0; k < 5; k++) begin
            bus26.config_enable = 1'b1;
            bus26.config_in     = bits[k];
            tick();
        end
        bus26.config_enable = 1'b0;
        bus26.data_in       = '1;
        bus26.config_latch  = 1'b1;
        tick();
        bus26.config_latch  = 1'b0;
        $display("latch sel=27 data_in=%h", bus26.data_in);
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL oor_data_out[%0d]: got %b expected 0", k, bus26.data_out); end
        end
        checks++; if (bus26.config_error !== 1'b1) begin errors++; $display("FAIL oor_error_sticky: got %b expected 1", bus26.config_error); end
    endtask

    // Active sel=3, shift 25 while toggling bits 3/25, latch+shift together.
    task automatic test_back_to_back();
        logic [4:0] bits3;
        logic [4:0] bits25;
        logic [4:0] sel_now;
        logic       v_cur;
        logic       v_prev;
        logic       exp_out;
        bits3  = 5'd3;
        bits25 = 5'd25;
        for (int k = 0; k < 5; k++) begin
            bus26.config_enable = 1'b1;
            bus26.config_in     = bits3[k];
            tick();
        end
        bus26.config_enable = 1'b0;
        bus26.data_in       = '0;
        bus26.config_latch  = 1'b1;
        tick();
        bus26.config_latch  = 1'b0;
        for (int k = 0; k <= LAT; k++) tick();
        sel_now = 5'd3;
        v_prev  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus26.data_in       = '0;
            bus26.data_in[3]    = i[0];
            bus26.data_in[25]   = ~i[0];
            bus26.config_enable = 1'b1;
            bus26.config_in     = (i < 5) ? bits25[i] : 1'b1;
            bus26.config_latch  = (i == 5);
            v_cur = bus26.data_in[sel_now];
            tick();
            exp_out = (LAT == 1) ? v_cur : v_prev;
            v_prev  = v_cur;
            if (i == 5) begin
                sel_now = 5'd25;
                $display("latch sel=25 with simultaneous shift");
            end
            checks++; if (bus26.data_out !== exp_out) begin errors++; $display("FAIL b2b_data_out[%0d]: got %b expected %b", i, bus26.data_out, exp_out); end
            if (i == 5 || i == 8 || i == 9) begin
                checks++; if (bus26.config_ready !== (i == 9)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus26.config_ready, (i == 9)); end
            end
        end
        bus26.config_enable = 1'b0;
        bus26.config_latch  = 1'b0;
    endtask

    // Asynchronous reset with a live configuration, then mid-shift.
    task automatic test_async_reset();
        bus26.data_in = '1;
        for (int k = 0; k < 5; k++) begin
            bus26.config_enable = 1'b1;
            bus26.config_in     = 1'b1;
            tick();
        end
        bus26.config_enable = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
        checks++; if (bus26.data_out !== 1'b1) begin errors++; $display("FAIL live_data_out: got %b expected 1", bus26.data_out); end
        checks++; if (bus26.config_out !== 1'b1) begin errors++; $display("FAIL live_config_out: got %b expected 1", bus26.config_out); end
        checks++; if (bus26.config_ready !== 1'b1) begin errors++; $display("FAIL live_ready: got %b expected 1", bus26.config_ready); end
        checks++; if (bus26.config_error !== 1'b1) begin errors++; $display("FAIL live_error: got %b expected 1", bus26.config_error); end
        #2 nreset = 1'b0;
        #1;
        $display("async reset with live config");
        checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL async_data_out: got %b expected 0", bus26.data_out); end
        checks++; if (bus26.config_out !== 1'b0) begin errors++; $display("FAIL async_config_out: got %b expected 0", bus26.config_out); end
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", bus26.config_ready); end
        checks++; if (bus26.config_error !== 1'b0) begin errors++; $display("FAIL async_error: got %b expected 0", bus26.config_error); end
        tick();
        #2 nreset = 1'b1;
        bus26.config_enable = 1'b1;
        bus26.config_in     = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL partial_ready: got %b expected 0", bus26.config_ready); end
        #2 nreset = 1'b0;
        #1;
        $display("async reset after 4 shifts");
        tick();
        #2 nreset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (bus26.config_ready !== 1'b0) begin errors++; $display("FAIL fresh_ready_4: got %b expected 0", bus26.config_ready); end
        tick();
        checks++; if (bus26.config_ready !== 1'b1) begin errors++; $display("FAIL fresh_ready_5: got %b expected 1", bus26.config_ready); end
        checks++; if (bus26.data_out !== 1'b0) begin errors++; $display("FAIL fresh_data_out: got %b expected 0", bus26.data_out); end
        bus26.config_enable = 1'b0;
    endtask

    // Random selector and data on all three widths.
    task automatic test_sweep();
        logic [7:0]   s2, s26, s256;
        logic [1:0]   d2;
        logic [25:0]  d26;
        logic [255:0] d256;
        logic         c2, c26, c256;
        logic         p2, p26, p256;
        logic         e2, e26, e256;
        for (int t = 0; t < 4; t++) begin
            s2   = 8'($urandom_range(0, 1));
            s26  = 8'($urandom_range(0, 31));
            s256 = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) begin
                bus2.config_enable   = (i < 1);
                bus2.config_in       = (i < 1) ? s2[i] : 1'b0;
                bus26.config_enable  = (i < 5);
                bus26.config_in      = (i < 5) ? s26[i] : 1'b0;
                bus256.config_enable = 1'b1;
                bus256.config_in     = s256[i];
                tick();
            end
            idle_all();
            bus2.config_latch = 1'b1; bus26.config_latch = 1'b1; bus256.config_latch = 1'b1;
            tick();
            idle_all();
            $display("sweep trial %0d sel2=%0d sel26=%0d sel256=%0d", t, s2, s26, s256);
            p2 = 1'b0; p26 = 1'b0; p256 = 1'b0;
            for (int i = 0; i < 6; i++) begin
                d2  = 2'($urandom());
                d26 = 26'($urandom());
                for (int k = 0; k < 8; k++) d256[k*32 +: 32] = $urandom();
                bus2.data_in = d2; bus26.data_in = d26; bus256.data_in = d256;
                c2   = d2[s2[0]];
                c26  = (s26 < 8'd26) ? d26[s26[4:0]] : 1'b0;
                c256 = d256[s256];
                tick();
                e2   = (LAT == 1) ? c2   : p2;
                e26  = (LAT == 1) ? c26  : p26;
                e256 = (LAT == 1) ? c256 : p256;
                p2 = c2; p26 = c26; p256 = c256;
                if (LAT == 1 || i > 0) begin
                    checks++; if (bus2.data_out !== e2) begin errors++; $display("FAIL sweep_n2[%0d.%0d]: got %b expected %b", t, i, bus2.data_out, e2); end
                    checks++; if (bus26.data_out !== e26) begin errors++; $display("FAIL sweep_n26[%0d.%0d]: got %b expected %b", t, i, bus26.data_out, e26); end
                    checks++; if (bus256.data_out !== e256) begin errors++; $display("FAIL sweep_n256[%0d.%0d]: got %b expected %b", t, i, bus256.data_out, e256); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_select();
        test_early_latch();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
